// File: rtl/uart_tx.sv
// uart_tx: unbuffered UART transmitter.
// Sends a start bit, 5-8 data bits LSB first, optional even/odd parity and
// 1 or 2 stop bits. Each bit lasts 16 brgCLKEN pulses from the shared BRG.
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       brgCLKEN,
    input  logic [1:0] length,
    input  logic       stop,
    input  logic [1:0] parity,
    input  logic [7:0] data,
    input  logic       load,
    output logic       empty,
    output logic       intr,
    output logic       txd
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 4;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        BIT0   = 4'd2,
        BIT1   = 4'd3,
        BIT2   = 4'd4,
        BIT3   = 4'd5,
        BIT4   = 4'd6,
        BIT5   = 4'd7,
        BIT6   = 4'd8,
        BIT7   = 4'd9,
        PARITY = 4'd10,
        STOP1  = 4'd11,
        STOP2  = 4'd12,
        DONE   = 4'd13
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    brdiv;
    logic [DATA_W-1:0]   shift;
    logic [CNT_W-1:0]    bitcnt;
    logic [CNT_W-1:0]    lastbit;
    logic                par_en;
    logic                par_bit;
    logic                stop2;

    // Character mask and parity of the character presented with load
    logic [DATA_W-1:0]   mask_c;
    logic [DATA_W-1:0]   masked_c;
    logic                par_bit_c;

    // Mask off bits above the selected length and precompute the parity bit
    always_comb begin
        mask_c    = 8'hFF >> (2'd3 - length);
        masked_c  = data & mask_c;
        par_bit_c = (^masked_c) ^ (parity == 2'b10);
    end

    // Transmit state machine with registered txd/empty/intr
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= IDLE;
            brdiv   <= '0;
            shift   <= '0;
            bitcnt  <= '0;
            lastbit <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            stop2   <= 1'b0;
            txd     <= 1'b1;
            empty   <= 1'b1;
            intr    <= 1'b0;
        end else begin
            intr <= 1'b0;
            if (load && empty) begin
                shift   <= masked_c;
                lastbit <= CNT_W'(3'd4 + CNT_W'(length));
                par_en  <= ^parity;
                par_bit <= par_bit_c;
                stop2   <= stop;
                bitcnt  <= '0;
                brdiv   <= 4'd15;
                state   <= START;
                txd     <= 1'b0;
                empty   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        txd   <= 1'b1;
                        empty <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                        empty <= 1'b1;
                    end
                    START, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7,
                    PARITY, STOP1, STOP2: begin
                        if (brgCLKEN) begin
                            if (brdiv != '0) begin
                                brdiv <= brdiv - 4'd1;
                            end else begin
                                brdiv <= 4'd15;
                                case (state)
                                    START: begin
                                        state  <= BIT0;
                                        txd    <= shift[0];
                                        shift  <= shift >> 1;
                                        bitcnt <= '0;
                                    end
                                    BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
                                        if (bitcnt == lastbit) begin
                                            if (par_en) begin
                                                state <= PARITY;
                                                txd   <= par_bit;
                                            end else begin
                                                state <= STOP1;
                                                txd   <= 1'b1;
                                            end
                                        end else begin
                                            state  <= state_t'(state + 4'd1);
                                            txd    <= shift[0];
                                            shift  <= shift >> 1;
                                            bitcnt <= bitcnt + 3'd1;
                                        end
                                    end
                                    PARITY: begin
                                        state <= STOP1;
                                        txd   <= 1'b1;
                                    end
                                    STOP1: begin
                                        txd <= 1'b1;
                                        if (stop2) begin
                                            state <= STOP2;
                                        end else begin
                                            state <= DONE;
                                            intr  <= 1'b1;
                                            empty <= 1'b1;
                                        end
                                    end
                                    STOP2: begin
                                        state <= DONE;
                                        txd   <= 1'b1;
                                        intr  <= 1'b1;
                                        empty <= 1'b1;
                                    end
                                    default: begin
                                        state <= IDLE;
                                        txd   <= 1'b1;
                                        empty <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                        empty <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a
// bit-list frame model (one expected txd level per 16 brgCLKEN pulses).
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       brgCLKEN;
    logic [1:0] length;
    logic       stop;
    logic [1:0] parity;
    logic [7:0] data;
    logic       load;
    logic       empty;
    logic       intr;
    logic       txd;

    int checks   = 0;
    int failures = 0;

    logic exp_bits[$];

    uart_tx dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .brgCLKEN(brgCLKEN),
        .length  (length),
        .stop    (stop),
        .parity  (parity),
        .data    (data),
        .load    (load),
        .empty   (empty),
        .intr    (intr),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels of a whole frame, one entry per bit time
    task automatic make_frame(input logic [7:0] d, input logic [1:0] len,
                              input logic [1:0] par, input logic stp);
        int n;
        int ones;
        n    = 5 + int'(len);
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2'b01) exp_bits.push_back(1'((ones % 2) != 0));
        else if (par == 2'b10) exp_bits.push_back(1'((ones % 2) == 0));
        exp_bits.push_back(1'b1);
        if (stp) exp_bits.push_back(1'b1);
    endtask

    // Idle cycles with random brgCLKEN: line high, empty, no interrupt
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            brgCLKEN = 1'($urandom_range(1));
            data     = 8'($urandom);
            @(posedge clk); #1;
            chk(tag, {29'd0, intr, empty, txd}, 32'b011);
        end
    endtask

    // Send one frame; optionally inject an ignored load or abort it with clr/rst
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] len,
                             input logic [1:0] par, input logic stp, input int brg_pct,
                             input int inj_at, input int abort_at, input bit abort_rst);
        int  total;
        int  pulses;
        int  cyc;
        int  fail0;
        bit  injected;
        bit  do_abort;
        bit  taken;
        make_frame(d, len, par, stp);
        total    = exp_bits.size() * 16;
        data     = d;
        length   = len;
        parity   = par;
        stop     = stp;
        load     = 1'b1;
        brgCLKEN = 1'($urandom_range(99) < brg_pct);
        @(posedge clk); #1;
        load   = 1'b0;
        pulses = 0;
        cyc    = 0;
        injected = 1'b0;
        chk({tag, "_start"}, {29'd0, intr, empty, txd}, 32'b000);
        forever begin
            data     = 8'($urandom);
            length   = 2'($urandom);
            parity   = 2'($urandom);
            stop     = 1'($urandom);
            brgCLKEN = 1'($urandom_range(99) < brg_pct);
            load     = 1'($urandom_range(49) == 0);
            if (inj_at >= 0 && !injected && pulses >= inj_at) begin
                load     = 1'b1;
                data     = 8'h00;
                injected = 1'b1;
            end
            do_abort = (abort_at >= 0 && pulses >= abort_at);
            if (do_abort) begin
                if (abort_rst) rst = 1'b1;
                else clr = 1'b1;
            end
            @(posedge clk); #1;
            taken = brgCLKEN;
            rst   = 1'b0;
            clr   = 1'b0;
            load  = 1'b0;
            if (do_abort) begin
                chk({tag, "_abort"}, {29'd0, intr, empty, txd}, 32'b011);
                idle_cycles(40, {tag, "_postabort"});
                return;
            end
            if (taken) pulses++;
            if (pulses == total) begin
                chk({tag, "_done"}, {29'd0, intr, empty, txd}, 32'b111);
                return;
            end
            fail0 = failures;
            chk({tag, "_bit"}, {29'd0, intr, empty, txd}, {31'd0, exp_bits[pulses / 16]});
            if (failures != fail0) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            cyc++;
            if (cyc > 20000) begin
                chk({tag, "_timeout"}, 32'd0, 32'd1);
                return;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        brgCLKEN = 1'b0;
        length   = 2'b11;
        stop     = 1'b0;
        parity   = 2'b00;
        data     = 8'h00;
        load     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {29'd0, intr, empty, txd}, 32'b011);
        rst = 1'b0;
        idle_cycles(5, "idle0");

        // 8N1 0x55, 7E1 0xC1, 5O2 0xFF with a pulse every clock
        run_frame("8n1", 8'h55, 2'b11, 2'b00, 1'b0, 100, -1, -1, 1'b0);
        idle_cycles(3, "gap1");
        run_frame("7e1", 8'hC1, 2'b10, 2'b01, 1'b0, 100, -1, -1, 1'b0);
        idle_cycles(3, "gap2");
        run_frame("5o2", 8'hFF, 2'b00, 2'b10, 1'b1, 100, -1, -1, 1'b0);
        idle_cycles(3, "gap3");

        // Load of 0x00 during BIT3 must be ignored
        run_frame("ldbit3", 8'hA7, 2'b11, 2'b01, 1'b0, 60, 4 * 16 + 3, -1, 1'b0);
        idle_cycles(3, "gap4");

        // clr in the middle of the parity bit, then a normal frame
        run_frame("clrpar", 8'h3C, 2'b11, 2'b10, 1'b1, 70, -1, 9 * 16 + 5, 1'b0);
        run_frame("afterclr", 8'h96, 2'b11, 2'b01, 1'b1, 100, -1, -1, 1'b0);
        idle_cycles(3, "gap5");

        // clr together with load while idle: nothing starts
        clr  = 1'b1;
        load = 1'b1;
        data = 8'h00;
        @(posedge clk); #1;
        clr  = 1'b0;
        load = 1'b0;
        chk("clrload", {29'd0, intr, empty, txd}, 32'b011);
        idle_cycles(40, "clrload_idle");

        // rst in the middle of a frame
        run_frame("rstmid", 8'h5A, 2'b01, 2'b00, 1'b0, 80, -1, 3 * 16 + 7, 1'b1);

        // Random frames, some back-to-back
        for (int k = 0; k < 24; k++) begin
            run_frame("rnd", 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                      int'($urandom_range(100, 30)), -1, -1, 1'b0);
            if ($urandom_range(1) == 0) idle_cycles(int'($urandom_range(4, 1)), "rndgap");
        end
        idle_cycles(5, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
